// File: rtl/region_reader.sv
// region_reader: walks a rectangular framebuffer region one pixel per cycle,
// issues read addresses for the on-screen pixels and compares the returned
// colours against a target colour. It reports whether any pixel matched, how
// many matched (saturating) and where the first row-major match was.
// Optional feature: define REGION_READER_EARLY_EXIT_EN to end the scan on the
// first match.
module region_reader #(
    parameter int SCREEN_W   = 160,
    parameter int SCREEN_H   = 120,
    parameter int RD_LATENCY = 1
) (
    input  logic        clock,
    input  logic        reset_n,
    input  logic        start,
    input  logic [7:0]  x_pos,
    input  logic [6:0]  y_pos,
    input  logic [7:0]  width,
    input  logic [6:0]  height,
    input  logic [2:0]  target_colour,
    output logic        rd_en,
    output logic [14:0] rd_addr,
    input  logic [2:0]  rd_data,
    output logic        busy,
    output logic        done,
    output logic        hit,
    output logic [14:0] match_count,
    output logic [7:0]  x_hit,
    output logic [6:0]  y_hit
);

    typedef enum logic [1:0] {IDLE, SCAN, DRAIN, DONE} state_t;

    state_t      state, state_next;

    logic [7:0]  x_base, width_r;
    logic [6:0]  y_base, height_r;
    logic [2:0]  target_r;
    logic [7:0]  cx, cx_next;
    logic [6:0]  cy, cy_next;
    logic [1:0]  drain_cnt;
    logic        last_pixel;
    logic        issue_valid, issue_on_screen;
    logic [8:0]  issue_x;
    logic [7:0]  issue_y;
    logic [14:0] issue_addr;
    logic        ret_match, stop_scan;
    logic [7:0]  tag_x;
    logic [6:0]  tag_y;

    logic [RD_LATENCY:1] pipe_vld;
    logic [7:0]          pipe_x [1:RD_LATENCY];
    logic [6:0]          pipe_y [1:RD_LATENCY];

    // Row-major walk: find the pixel after the one currently being read.
    always_comb begin
        last_pixel = (cx == width_r) && (cy == height_r);
        cx_next    = cx + 8'd1;
        cy_next    = cy;
        if (cx == width_r) begin
            cx_next = 8'd0;
            cy_next = cy + 7'd1;
        end
    end

    // A returned colour counts only if its read was real; with early exit
    // only the first match of a scan is taken and later returns are dropped.
    always_comb begin
        ret_match = pipe_vld[RD_LATENCY] && (rd_data == target_r);
`ifdef REGION_READER_EARLY_EXIT_EN
        ret_match = ret_match && !hit;
        stop_scan = ret_match && (state == SCAN);
`else
        stop_scan = 1'b0;
`endif
    end

    // Pick the pixel whose read is registered at this edge and clip it.
    always_comb begin
        issue_valid = 1'b0;
        issue_x     = {1'b0, x_pos};
        issue_y     = {1'b0, y_pos};
        if (state == IDLE && start) begin
            issue_valid = 1'b1;
        end else if (state == SCAN && !last_pixel && !stop_scan) begin
            issue_valid = 1'b1;
            issue_x     = {1'b0, x_base} + {1'b0, cx_next};
            issue_y     = {1'b0, y_base} + {1'b0, cy_next};
        end
        issue_on_screen = (issue_x < 9'(SCREEN_W)) && (issue_y < 8'(SCREEN_H));
        issue_addr      = 15'(issue_y) * 15'(SCREEN_W) + 15'(issue_x);
    end

    // Next-state decode for the scan sequencer.
    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (start) state_next = SCAN;
            SCAN:    if (last_pixel || stop_scan) state_next = DRAIN;
            DRAIN:   if (drain_cnt == 2'(RD_LATENCY - 1)) state_next = DONE;
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign busy = (state == SCAN) || (state == DRAIN);
    assign done = (state == DONE);

    // State register.
    always_ff @(posedge clock) begin
        if (!reset_n) state <= IDLE;
        else          state <= state_next;
    end

    // Latch the request on start, step the pixel counters and time the drain.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            x_base    <= '0;
            y_base    <= '0;
            width_r   <= '0;
            height_r  <= '0;
            target_r  <= '0;
            cx        <= '0;
            cy        <= '0;
            drain_cnt <= '0;
        end else begin
            if (state == IDLE && start) begin
                x_base   <= x_pos;
                y_base   <= y_pos;
                width_r  <= width;
                height_r <= height;
                target_r <= target_colour;
                cx       <= '0;
                cy       <= '0;
            end else if (state == SCAN) begin
                cx <= cx_next;
                cy <= cy_next;
            end
            if (state == DRAIN) drain_cnt <= drain_cnt + 2'd1;
            else                drain_cnt <= '0;
        end
    end

    // Registered read strobe and address, with the pixel coordinate as a tag.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rd_en   <= 1'b0;
            rd_addr <= '0;
            tag_x   <= '0;
            tag_y   <= '0;
        end else begin
            rd_en <= issue_valid && issue_on_screen;
            if (issue_valid && issue_on_screen) begin
                rd_addr <= issue_addr;
                tag_x   <= issue_x[7:0];
                tag_y   <= issue_y[6:0];
            end
        end
    end

    // Carry valid bit and coordinate alongside each read until its data returns.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            pipe_vld <= '0;
            for (int k = 1; k <= RD_LATENCY; k++) begin
                pipe_x[k] <= '0;
                pipe_y[k] <= '0;
            end
        end else begin
            pipe_vld[1] <= rd_en;
            pipe_x[1]   <= tag_x;
            pipe_y[1]   <= tag_y;
            for (int k = 2; k <= RD_LATENCY; k++) begin
                pipe_vld[k] <= pipe_vld[k-1];
                pipe_x[k]   <= pipe_x[k-1];
                pipe_y[k]   <= pipe_y[k-1];
            end
        end
    end

    // Accumulate results; they are cleared only by reset or an accepted start.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            hit         <= 1'b0;
            match_count <= '0;
            x_hit       <= '0;
            y_hit       <= '0;
        end else if (state == IDLE && start) begin
            hit         <= 1'b0;
            match_count <= '0;
            x_hit       <= '0;
            y_hit       <= '0;
        end else if (ret_match) begin
            hit <= 1'b1;
            if (match_count != 15'h7FFF) match_count <= match_count + 15'd1;
            if (!hit) begin
                x_hit <= pipe_x[RD_LATENCY];
                y_hit <= pipe_y[RD_LATENCY];
            end
        end
    end

endmodule

// File: tb/tb_region_reader.sv
// tb_region_reader: directed scans of region_reader against a framebuffer
// model. The expected read trace, done cycle and results are derived from
// the region geometry and framebuffer contents with plain loops.
module tb_region_reader;

    localparam int LAT = 3;
    localparam int SW  = 160;
    localparam int SH  = 120;
`ifdef REGION_READER_EARLY_EXIT_EN
    localparam bit EARLY = 1'b1;
`else
    localparam bit EARLY = 1'b0;
`endif

    logic        clock;
    logic        reset_n;
    logic        start;
    logic [7:0]  x_pos;
    logic [6:0]  y_pos;
    logic [7:0]  width;
    logic [6:0]  height;
    logic [2:0]  target_colour;
    logic        rd_en;
    logic [14:0] rd_addr;
    logic [2:0]  rd_data;
    logic        busy;
    logic        done;
    logic        hit;
    logic [14:0] match_count;
    logic [7:0]  x_hit;
    logic [6:0]  y_hit;

    int checkCount = 0;
    int passCount  = 0;

    logic [2:0] fb [0:SW*SH-1];
    logic [2:0] dp [1:LAT];

    bit expEn[];
    int expAddr[];
    int mdlDone, mdlCount, mdlX, mdlY;
    bit mdlHit;
    int obsReads;
    bit aborted;

    region_reader #(.SCREEN_W(SW), .SCREEN_H(SH), .RD_LATENCY(LAT)) dut (
        .clock(clock), .reset_n(reset_n), .start(start),
        .x_pos(x_pos), .y_pos(y_pos), .width(width), .height(height),
        .target_colour(target_colour), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .busy(busy), .done(done), .hit(hit),
        .match_count(match_count), .x_hit(x_hit), .y_hit(y_hit)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Framebuffer with a fixed read latency; 3'b101 marks a non-read cycle.
    always @(posedge clock) begin
        dp[1] <= rd_en ? fb[rd_addr] : 3'b101;
        for (int k = 2; k <= LAT; k++) dp[k] <= dp[k-1];
    end
    assign rd_data = dp[LAT];

    task automatic checkOutput(input string name, input int actual, input int expected);
        checkCount++;
        if (actual == expected) passCount++;
        else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    endtask

    task automatic applyStimulus(input int xp, input int yp, input int w, input int h,
                                 input logic [2:0] tgt, input logic st);
        x_pos         = 8'(xp);
        y_pos         = 7'(yp);
        width         = 8'(w);
        height        = 7'(h);
        target_colour = tgt;
        start         = st;
    endtask

    task automatic fillFb(input logic [2:0] c);
        for (int i = 0; i < SW*SH; i++) fb[i] = c;
    endtask

    // Expected behaviour: scan cycle k (1-based after the accepting edge)
    // reads pixel k-1 in row-major order if it is on screen.
    task automatic buildModel(input int xp, input int yp, input int w, input int h,
                              input logic [2:0] tgt);
        int n, idx, first, cnt, issueEnd, x, y;
        bit onArr[];
        int addrArr[];
        n = (w + 1) * (h + 1);
        onArr = new[n];
        addrArr = new[n];
        first = -1;
        cnt = 0;
        mdlX = 0;
        mdlY = 0;
        idx = 0;
        for (int cy = 0; cy <= h; cy++) begin
            for (int cx = 0; cx <= w; cx++) begin
                x = xp + cx;
                y = yp + cy;
                onArr[idx] = (x < SW) && (y < SH);
                addrArr[idx] = y * SW + x;
                if (onArr[idx] && fb[addrArr[idx]] == tgt) begin
                    cnt++;
                    if (first < 0) begin
                        first = idx;
                        mdlX = x;
                        mdlY = y;
                    end
                end
                idx++;
            end
        end
        issueEnd = n;
        mdlDone = n + LAT + 1;
        if (EARLY && first >= 0) begin
            cnt = 1;
            if (first + 1 + LAT <= n) begin
                issueEnd = first + 1 + LAT;
                mdlDone = issueEnd + LAT + 1;
            end
        end
        if (cnt > 32767) cnt = 32767;
        mdlCount = cnt;
        mdlHit = (first >= 0);
        expEn = new[mdlDone + 1];
        expAddr = new[mdlDone + 1];
        for (int k = 1; k <= mdlDone; k++) begin
            expEn[k] = (k <= issueEnd) ? onArr[k-1] : 1'b0;
            expAddr[k] = (k <= issueEnd) ? addrArr[k-1] : 0;
        end
    endtask

    // Start a scan, scramble the inputs, and compare every cycle to the model.
    task automatic runScan(input int xp, input int yp, input int w, input int h,
                           input logic [2:0] tgt, input int pulseAt, input int resetAt);
        buildModel(xp, yp, w, h, tgt);
        obsReads = 0;
        aborted = 1'b0;
        @(negedge clock);
        applyStimulus(xp, yp, w, h, tgt, 1'b1);
        @(posedge clock);
        for (int k = 1; k <= mdlDone; k++) begin
            @(negedge clock);
            if (k == 1) applyStimulus(3, 3, 1, 1, ~tgt, 1'b0);
            if (k == resetAt) begin
                reset_n = 1'b0;
                aborted = 1'b1;
                break;
            end
            if (rd_en) obsReads++;
            checkOutput($sformatf("rd_en@%0d", k), int'(rd_en), int'(expEn[k]));
            if (expEn[k]) checkOutput($sformatf("rd_addr@%0d", k), int'(rd_addr), expAddr[k]);
            checkOutput($sformatf("busy@%0d", k), int'(busy), int'(k < mdlDone));
            checkOutput($sformatf("done@%0d", k), int'(done), int'(k == mdlDone));
            if (k == mdlDone) begin
                checkOutput("hit", int'(hit), int'(mdlHit));
                checkOutput("match_count", int'(match_count), mdlCount);
                checkOutput("x_hit", int'(x_hit), mdlHit ? mdlX : 0);
                checkOutput("y_hit", int'(y_hit), mdlHit ? mdlY : 0);
            end
            if (k == pulseAt) start = 1'b1;
            else if (k == pulseAt + 1) start = 1'b0;
        end
    endtask

    initial begin
        reset_n = 1'b0;
        applyStimulus(0, 0, 0, 0, 3'b000, 1'b0);
        fillFb(3'b000);
        repeat (3) @(posedge clock);
        @(negedge clock);
        checkOutput("reset rd_en", int'(rd_en), 0);
        checkOutput("reset busy", int'(busy), 0);
        checkOutput("reset done", int'(done), 0);
        checkOutput("reset hit", int'(hit), 0);
        checkOutput("reset match_count", int'(match_count), 0);
        checkOutput("reset x_hit", int'(x_hit), 0);
        checkOutput("reset y_hit", int'(y_hit), 0);
        reset_n = 1'b1;

        $display("[TB] single match in 5x5 region");
        fb[20*SW + 10] = 3'b010;
        runScan(8, 18, 4, 4, 3'b010, 0, 0);
        checkOutput("t1 model done", mdlDone, 25 + LAT + 1);
        checkOutput("t1 model x", mdlX, 10);
        checkOutput("t1 match_count", int'(match_count), 1);
        checkOutput("t1 x_hit", int'(x_hit), 10);
        checkOutput("t1 y_hit", int'(y_hit), 20);
        if (!EARLY) checkOutput("t1 reads", obsReads, 25);

        $display("[TB] clipped region at bottom-right corner");
        fillFb(3'b010);
        runScan(150, 115, 20, 10, 3'b010, 0, 0);
        checkOutput("t2 match_count", int'(match_count), EARLY ? 1 : 50);
        if (!EARLY) checkOutput("t2 reads", obsReads, 50);

        $display("[TB] maximum region clipped to full screen");
        runScan(0, 0, 255, 127, 3'b010, 0, 0);
        checkOutput("t3 match_count", int'(match_count), EARLY ? 1 : 19200);
        checkOutput("t3 hit", int'(hit), 1);

        $display("[TB] start while busy, then reset mid-scan");
        fillFb(3'b000);
        fb[20*SW + 10] = 3'b010;
        runScan(8, 18, 4, 4, 3'b010, 5, 12);
        checkOutput("t4 aborted", int'(aborted), 1);
        @(negedge clock);
        checkOutput("t4 busy", int'(busy), 0);
        checkOutput("t4 done", int'(done), 0);
        checkOutput("t4 hit", int'(hit), 0);
        checkOutput("t4 match_count", int'(match_count), 0);
        checkOutput("t4 rd_en", int'(rd_en), 0);
        reset_n = 1'b1;
        runScan(8, 18, 4, 4, 3'b010, 0, 0);
        checkOutput("t4 fresh match_count", int'(match_count), 1);

        $display("[TB] three matches in 5x5 region");
        fillFb(3'b000);
        fb[30*SW + 41] = 3'b010;
        fb[31*SW + 43] = 3'b010;
        fb[33*SW + 40] = 3'b010;
        runScan(40, 30, 4, 4, 3'b010, 0, 0);
        checkOutput("t5 match_count", int'(match_count), EARLY ? 1 : 3);
        checkOutput("t5 x_hit", int'(x_hit), 41);
        checkOutput("t5 y_hit", int'(y_hit), 30);
        checkOutput("t5 reads", obsReads, EARLY ? 1 + 1 + LAT : 25);

        $display("[TB] single-pixel region");
        fb[60*SW + 70] = 3'b010;
        runScan(70, 60, 0, 0, 3'b010, 0, 0);
        checkOutput("t6 model done", mdlDone, 5);
        checkOutput("t6 reads", obsReads, 1);
        checkOutput("t6 hit", int'(hit), 1);

        $display("%0d/%0d checks passed", passCount, checkCount);
        $finish;
    end

endmodule

// File: doc/region_reader.md
# region_reader

Read-back engine for the 160x120, 3-bit-colour framebuffer that the rectangle drawers write into. Given a rectangle in the same x_pos/y_pos/width/height form the drawers use, it walks the region one pixel per cycle and issues framebuffer read addresses. It compares each returned colour against a target colour and reports whether any pixel matched, how many matched, and where the first match was. Game logic uses it for puck/paddle/boundary collision tests between frame redraws.

## Interface
- SCREEN_W, 160: framebuffer columns; address stride.
- SCREEN_H, 120: framebuffer rows.
- RD_LATENCY, 1: cycles from rd_en to valid rd_data; legal values 1..3.

- clock  in  1  system clock
- reset_n  in  1  synchronous, active-low reset
- start  in  1  request a scan; sampled only in IDLE
- x_pos  in  8  region left column
- y_pos  in  7  region top row
- width  in  8  region spans x_pos..x_pos+width inclusive
- height  in  7  region spans y_pos..y_pos+height inclusive
- target_colour  in  3  colour to match
- rd_en  out  1  framebuffer read strobe
- rd_addr  out  15  y*SCREEN_W + x
- rd_data  in  3  colour returned RD_LATENCY cycles after rd_en
- busy  out  1  high from the cycle after an accepted start until done
- done  out  1  one-cycle pulse at end of scan
- hit  out  1  at least one match in the last scan
- match_count  out  15  matches in the last scan, saturating at 32767
- x_hit  out  8  column of first match (row-major order)
- y_hit  out  7  row of first match

## Operation
- FSM states: IDLE, SCAN, DRAIN, DONE.
- IDLE:
  - On start=1, latch x_pos, y_pos, width, height and target_colour.
  - Clear hit, match_count, x_hit and y_hit.
  - Reset counters cx=0, cy=0, then go to SCAN.
- SCAN: one pixel per cycle at (x_pos+cx, y_pos+cy), using 9-bit and 8-bit sums with no wrap.
  - If the pixel is on-screen (x<SCREEN_W and y<SCREEN_H): rd_en=1, rd_addr=y*SCREEN_W+x.
  - If off-screen: rd_en=0 and the cycle is still consumed. Clipped pixels are never counted.
  - cx increments to width, then wraps to 0 and cy increments.
  - After issuing (cx=width, cy=height), go to DRAIN.
- Return path: a RD_LATENCY-deep shift register carries the valid bit and (x,y) alongside each read.
  - When a valid entry emerges and rd_data==target_colour: set hit, saturate-increment match_count.
  - If hit was clear, also load x_hit/y_hit.
- DRAIN: hold for RD_LATENCY cycles so in-flight reads retire, then go to DONE.
- DONE: done=1 for one cycle, busy=0, then IDLE.
- hit, match_count, x_hit and y_hit hold their values until the next accepted start.
- start while busy: ignored, no queuing. start held high: a new scan starts in the IDLE cycle after DONE.
- Input changes during a scan have no effect, because all inputs are latched.
- Reset or reset mid-scan: next edge forces IDLE. All outputs go to 0: rd_en, rd_addr, busy, done, hit, match_count, x_hit, y_hit. In-flight returns are discarded.

## Timing
- Start accepted at edge T. The first rd_en is in cycle T+1, and busy is high from T+1.
- An N=(width+1)*(height+1) pixel scan issues reads in cycles T+1..T+N.
- DRAIN occupies RD_LATENCY cycles and the done pulse follows, at cycle T+N+RD_LATENCY+1.
- Results are stable when done is high.
- Back-to-back: minimum start-to-start spacing is N+RD_LATENCY+2 cycles.
- rd_en and rd_addr are registered outputs.

## Configuration
- REGION_READER_EARLY_EXIT_EN defined:
  - The first match ends SCAN immediately; no further rd_en is issued. The FSM goes through DRAIN and then DONE.
  - Reads already in flight are discarded, so match_count=1 and hit=1.
  - done arrives RD_LATENCY+1 cycles after the matching data returns.
- Not defined: every scan covers the full region, and match_count is exact (saturating).

## Test plan
- Framebuffer filled with 0 except (10,20)=3'b010. Region x=8,y=18,w=4,h=4, target 010:
  - 25 reads, hit=1, match_count=1, x_hit=10, y_hit=20.
  - done at T+25+RD_LATENCY+1.
- Region x=150,y=115,w=20,h=10 over an all-010 buffer, target 010:
  - Only the 10x5 on-screen area is read; rd_en is never high with x>=160 or y>=120.
  - match_count=50.
- Full-region scan x=0,y=0,w=255,h=127 over an all-match buffer:
  - match_count=19200 (clipped region); no saturation fault.
- start pulsed at scan cycle 5 of an active scan, then reset_n=0 at cycle 12:
  - The second start is ignored.
  - After reset, busy=0, done=0, hit=0, match_count=0, rd_en=0.
  - A fresh start then scans correctly.
- With REGION_READER_EARLY_EXIT_EN, 3 matching pixels in a 5x5 region, RD_LATENCY=2:
  - rd_en stops after the first match is detected.
  - match_count=1 and x_hit/y_hit equal the row-major-first match.
- RD_LATENCY=3, region w=0,h=0 on a matching pixel:
  - Exactly one rd_en, done at T+5, hit=1.
